// File: rtl/io_periph_bank.sv
// rtl/io_periph_bank.sv - memory-mapped LED/LCD/HEX bank with debounced switches and change interrupt
// Optional macro IO_HEX_DECODE_EN: drive HEX outputs as active-low seven-segment patterns.
module io_periph_bank #(
    parameter int N_HEX        = 8,
    parameter int DEBOUNCE_CYC = 16,
    parameter int ADDR_W       = 12
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 st_en_i,
    input  logic                 ld_en_i,
    input  logic [ADDR_W-1:0]    addr_i,
    input  logic [31:0]          wdata_i,
    input  logic [3:0]           be_i,
    output logic [31:0]          rdata_o,
    output logic                 rvalid_o,
    input  logic [31:0]          io_sw_i,
    output logic [31:0]          io_ledr_o,
    output logic [31:0]          io_ledg_o,
    output logic [31:0]          io_lcd_o,
    output logic [32*N_HEX-1:0]  io_hex_o,
    output logic                 sw_irq_o
);
    localparam int CW = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC - 1);

    logic [31:0]       ledr, ledg, lcd, sw_db, sw_chg, sw_meta, sw_s, cand;
    logic [31:0]       hex_q [N_HEX];
    logic [CW-1:0]     cnt, cnt_inc;
    logic [ADDR_W-1:0] a;
    logic [3:0]        hex_k;
    logic              hit_ledr, hit_ledg, hit_lcd, hit_hex, hit_sw, hit_chg, accept;
    logic [31:0]       bmask, rd, new_chg, clr, chg_next;

    assign a        = {addr_i[ADDR_W-1:2], 2'b00};
    assign hit_ledr = (a == ADDR_W'('h000));
    assign hit_ledg = (a == ADDR_W'('h004));
    assign hit_lcd  = (a == ADDR_W'('h008));
    assign hit_sw   = (a == ADDR_W'('h080));
    assign hit_chg  = (a == ADDR_W'('h084));
    assign hit_hex  = (a >= ADDR_W'('h010)) && (a < ADDR_W'('h010 + 4 * N_HEX));
    assign hex_k    = 4'(a[6:2] - 5'd4);
    assign bmask    = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};

    // cnt counts stable cycles including the one where cand was loaded, so a
    // clean step is accepted 2 + DEBOUNCE_CYC edges after it reaches the pins.
    assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
    assign accept   = (sw_s == cand) && (cnt_inc == CNT_MAX) && (cand != sw_db);
    assign new_chg  = accept ? (cand ^ sw_db) : 32'h0;
    assign clr      = (st_en_i && hit_chg) ? (wdata_i & bmask) : 32'h0;
    assign chg_next = (sw_chg & ~clr) | new_chg;

    always_comb begin
        rd = 32'h0;
        if (hit_ledr) rd = ledr;
        if (hit_ledg) rd = ledg;
        if (hit_lcd)  rd = lcd;
        if (hit_sw)   rd = sw_db;
        if (hit_chg)  rd = sw_chg;
        for (int k = 0; k < N_HEX; k++)
            if (hit_hex && hex_k == 4'(k)) rd = hex_q[k];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ledr     <= '0;
            ledg     <= '0;
            lcd      <= '0;
            for (int k = 0; k < N_HEX; k++) hex_q[k] <= '0;
            rdata_o  <= '0;
            rvalid_o <= 1'b0;
        end else begin
            rvalid_o <= ld_en_i;
            if (ld_en_i) rdata_o <= rd;
            if (st_en_i) begin
                if (hit_ledr) ledr <= (ledr & ~bmask) | (wdata_i & bmask);
                if (hit_ledg) ledg <= (ledg & ~bmask) | (wdata_i & bmask);
                if (hit_lcd)  lcd  <= (lcd  & ~bmask) | (wdata_i & bmask);
                for (int k = 0; k < N_HEX; k++)
                    if (hit_hex && hex_k == 4'(k))
                        hex_q[k] <= (hex_q[k] & ~bmask) | (wdata_i & bmask);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sw_meta  <= '0;
            sw_s     <= '0;
            cand     <= '0;
            cnt      <= '0;
            sw_db    <= '0;
            sw_chg   <= '0;
            sw_irq_o <= 1'b0;
        end else begin
            sw_meta <= io_sw_i;
            sw_s    <= sw_meta;
            if (sw_s != cand) begin
                cand <= sw_s;
                cnt  <= '0;
            end else begin
                cnt  <= cnt_inc;
            end
            if (accept) sw_db <= cand;
            sw_chg   <= chg_next;
            sw_irq_o <= |chg_next;
        end
    end

`ifdef IO_HEX_DECODE_EN
    function automatic logic [6:0] seg7_n(input logic [3:0] v);
        case (v)
            4'h0: seg7_n = 7'h40;  4'h1: seg7_n = 7'h79;
            4'h2: seg7_n = 7'h24;  4'h3: seg7_n = 7'h30;
            4'h4: seg7_n = 7'h19;  4'h5: seg7_n = 7'h12;
            4'h6: seg7_n = 7'h02;  4'h7: seg7_n = 7'h78;
            4'h8: seg7_n = 7'h00;  4'h9: seg7_n = 7'h10;
            4'hA: seg7_n = 7'h08;  4'hB: seg7_n = 7'h03;
            4'hC: seg7_n = 7'h46;  4'hD: seg7_n = 7'h21;
            4'hE: seg7_n = 7'h06;  default: seg7_n = 7'h0E;
        endcase
    endfunction

    for (genvar g = 0; g < N_HEX; g++) begin : g_hex
        assign io_hex_o[32*g +: 32] = {25'b0, seg7_n(hex_q[g][3:0])};
    end
`else
    for (genvar g = 0; g < N_HEX; g++) begin : g_hex
        assign io_hex_o[32*g +: 32] = hex_q[g];
    end
`endif

    assign io_ledr_o = ledr;
    assign io_ledg_o = ledg;
    assign io_lcd_o  = lcd;
endmodule

// File: tb/tb_io_periph_bank.sv
// tb/tb_io_periph_bank.sv - scoreboard bench for io_periph_bank (loads checked by a decoupled monitor)
module tb_io_periph_bank;
`ifdef IO_HEX_DECODE_EN
    localparam logic [31:0] HEX0_RST = 32'h40;
    localparam logic [31:0] HEX7_EXP = 32'h78;
`else
    localparam logic [31:0] HEX0_RST = 32'h0;
    localparam logic [31:0] HEX7_EXP = 32'h7;
`endif

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         st_en = 1'b0, ld_en = 1'b0;
    logic [11:0]  addr = '0;
    logic [31:0]  wdata = '0;
    logic [3:0]   be = '0;
    logic [31:0]  rdata, sw = '0, ledr, ledg, lcd;
    logic         rvalid, irq;
    logic [255:0] hex;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    io_periph_bank dut (
        .clk_i(clk), .rst_ni(rst_n), .st_en_i(st_en), .ld_en_i(ld_en),
        .addr_i(addr), .wdata_i(wdata), .be_i(be), .rdata_o(rdata),
        .rvalid_o(rvalid), .io_sw_i(sw), .io_ledr_o(ledr), .io_ledg_o(ledg),
        .io_lcd_o(lcd), .io_hex_o(hex), .sw_irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rvalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rvalid_spurious: got rvalid=1 expected no pending load");
            end else begin
                chk("load_rdata", rdata, exp_q.pop_front());
            end
        end
    end

    task automatic do_store(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
        @(posedge clk); #1;
        st_en = 1'b1; addr = a; wdata = d; be = b;
        @(posedge clk); #1;
        st_en = 1'b0;
    endtask

    task automatic do_load(input logic [11:0] a, input logic [31:0] e);
        @(posedge clk); #1;
        ld_en = 1'b1; addr = a;
        exp_q.push_back(e);
        @(posedge clk); #1;
        ld_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        sw = 32'd200;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ledr", ledr, 32'h0);
        chk("rst_ledg", ledg, 32'h0);
        chk("rst_lcd", lcd, 32'h0);
        chk("rst_hex0", hex[31:0], HEX0_RST);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
        chk("rst_irq", {31'b0, irq}, 32'h0);

        rst_n = 1'b1;
        repeat (17) @(posedge clk);
        #1 chk("db_irq_edge17", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1 chk("db_irq_edge18", {31'b0, irq}, 32'h1);
        do_load(12'h080, 32'd200);
        do_load(12'h084, 32'hC8);

        do_store(12'h000, 32'hAABBCCDD, 4'b0101);
        chk("ledr_bytes", ledr, 32'h00BB00DD);
        do_load(12'h000, 32'h00BB00DD);

        do_store(12'h080, 32'h12345678, 4'hF);
        do_load(12'h080, 32'd200);

        do_store(12'h084, 32'h000000FF, 4'b0001);
        chk("chg_clear_irq", {31'b0, irq}, 32'h0);
        do_load(12'h084, 32'h0);

        sw = 32'd201;
        repeat (5) @(posedge clk);
        #1 sw = 32'd200;
        repeat (25) @(posedge clk);
        #1 chk("glitch_irq", {31'b0, irq}, 32'h0);
        do_load(12'h080, 32'd200);
        do_load(12'h084, 32'h0);

        do_store(12'h02C, 32'h7, 4'hF);
        chk("hex7_out", hex[255:224], HEX7_EXP);
        do_load(12'h02C, 32'h7);
        do_store(12'h030, 32'h55, 4'hF);
        do_load(12'h030, 32'h0);
        do_load(12'h0FC, 32'h0);

        do_store(12'h004, 32'h1, 4'hF);
        @(posedge clk); #1;
        st_en = 1'b1; ld_en = 1'b1; addr = 12'h004; wdata = 32'h2; be = 4'hF;
        exp_q.push_back(32'h1);
        @(posedge clk); #1;
        st_en = 1'b0; ld_en = 1'b0;
        chk("ledg_same_cycle", ledg, 32'h2);

        sw = 32'h0F0;
        repeat (13) @(posedge clk);
        #1 rst_n = 1'b0;
        #2 chk("rst_mid_ledg", ledg, 32'h0);
        chk("rst_mid_irq", {31'b0, irq}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_load(12'h080, 32'h0);
        repeat (15) @(posedge clk);
        #1 chk("rdb_irq_edge17", {31'b0, irq}, 32'h0);
        @(posedge clk);
        #1 chk("rdb_irq_edge18", {31'b0, irq}, 32'h1);
        do_load(12'h080, 32'h0F0);
        do_load(12'h084, 32'h0F0);

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
